pipelined_write_decoder: RTL and testbench
==========================================

Name: pipelined_write_decoder

Overview:
- Parametrised, registered successor to the register-file write-address decoder.
- Accepts write-destination requests over a valid/ready handshake and decodes each address into a one-hot write-select after a configurable pipeline latency.
- Tracks outstanding writes in a per-register busy scoreboard and refuses a new write to a register that is still pending (WAW hold-off).
- Sits between the issue logic and the 32x64 register file write port.

Parameters:
- ADDR_W, 5, address width; decoded output width is NREG = 2**ADDR_W (localparam, not overridable).
- LAT, 1, pipeline stages from accept to out_valid, legal range 1..3; the last stage is the output register.
- ZERO_EN, 1, when 1 register index ZERO_IDX is a hard-wired zero register.
- ZERO_IDX, NREG-1, index of the zero register (31 at default width).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  request valid
- in_addr  in  ADDR_W  destination register index
- in_ready  out  1  combinational; request accepted when in_valid && in_ready
- flush  in  1  synchronous kill of all in-flight requests
- out_valid  out  1  registered; decoded select valid this cycle
- out_sel  out  NREG  registered one-hot write select
- out_addr  out  ADDR_W  registered index matching out_sel
- wb_valid  in  1  writeback completion strobe
- wb_addr  in  ADDR_W  index whose busy bit clears
- busy  out  NREG  registered scoreboard, bit i = write to i outstanding

Behaviour:
- Reset, asynchronous: all stage valids 0, out_valid 0, out_sel 0, out_addr 0, busy 0. In_ready is 1 while reset is held and immediately after release.
- in_ready = !busy[in_addr] && no valid pipeline stage (including the output stage) holds in_addr.
  - Exception: if ZERO_EN and in_addr==ZERO_IDX, in_ready=1 unconditionally.
  - In_ready uses registered state only; there is no bypass from wb_valid in the same cycle.
- Accept at edge k: the request enters stage 1. Each stage advances unconditionally every cycle; there is no back-pressure from the output. out_valid is high in the cycle following edge k+LAT-1, so with LAT=1 it is high the cycle right after accept.
- out_sel = one-hot of out_addr when out_valid=1, else all zero.
  - Zero register: out_valid=1, out_addr=ZERO_IDX, out_sel all zero. Its busy bit is never set.
- Busy set: on the edge that ends a cycle with out_valid=1 (non-zero reg), busy[out_addr] becomes 1.
- Busy clear: wb_valid on edge clears busy[wb_addr].
  - wb_valid to a non-busy index is ignored.
  - wb_valid on the zero register is ignored.
- Same-edge set and clear of the same index: set wins. This is unreachable under legal use and is checked by assertion.
- Multiple different indices: one set and one clear in the same edge both take effect.
- flush at edge: all stage valids, including the output stage, clear to 0. out_valid and out_sel are 0 the next cycle.
  - A request accepted in the same cycle as flush is discarded.
  - busy is unaffected; an in-flight output-stage entry killed by flush never sets busy.
- Reset mid-operation: all in-flight requests are lost and busy clears; no partial output is produced.
- Throughput: one accept per cycle to distinct registers. Back-to-back requests to the same index stall until writeback.
- Arithmetic: one-hot decode uses the full ADDR_W index. All NREG codes are legal; no out-of-range case exists.

Test Plan:
- Reset release, LAT=1: in_valid=1, in_addr=5 at cycle 0 → out_valid=1, out_sel=0x00000020, out_addr=5 in cycle 1. busy[5]=1 from cycle 2.
- Same-address hold-off: accept addr 7, re-present addr 7 → in_ready=0 until wb_valid/wb_addr=7. in_ready=1 the cycle after the wb edge, not the same cycle.
- Zero register: accept addr 31 three cycles in a row → in_ready stays 1. out_valid high for 3 cycles, out_sel=0 each cycle, busy stays 0.
- LAT=3 pipeline: accept addrs 1,2,3 on consecutive cycles → out_valid cycles 3,4,5 with out_sel 0x2,0x4,0x8. Presenting addr 2 while it is in flight gives in_ready=0.
- Flush: LAT=2, accept addr 9, flush one cycle later → out_valid never asserts, busy[9] stays 0, in_ready for addr 9 returns to 1.
- Async reset mid-stream: busy=0x0000_0F00 and a request in flight, pulse reset between edges → busy, out_valid and out_sel are 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/pipelined_write_decoder_if.sv
// Issue-side bundle for the pipelined write decoder:
// request handshake, decoded select, writeback strobe and busy scoreboard.
interface pipelined_write_decoder_if #(
    parameter int ADDR_W = 5
);
    localparam int NREG = 1 << ADDR_W;

    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [NREG-1:0]   out_sel;
    logic [ADDR_W-1:0] out_addr;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [NREG-1:0]   busy;

    modport master (
        output in_valid, in_addr, flush, wb_valid, wb_addr,
        input  in_ready, out_valid, out_sel, out_addr, busy
    );

    modport slave (
        input  in_valid, in_addr, flush, wb_valid, wb_addr,
        output in_ready, out_valid, out_sel, out_addr, busy
    );
endinterface

// File: rtl/pipelined_write_decoder.sv
// Registered write-address decoder with LAT-deep pipeline and
// per-register busy scoreboard providing WAW hold-off.
module pipelined_write_decoder #(
    parameter int ADDR_W   = 5,
    parameter int LAT      = 1,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = (1 << ADDR_W) - 1
) (
    input logic clk,
    input logic reset,
    pipelined_write_decoder_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_IDX);

    logic [LAT-1:0]    vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [LAT];
    logic [ADDR_W-1:0] addr_d [LAT];
    logic [NREG-1:0]   sel_q, sel_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              hit, accept, set_en;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_EN != 0) && (a == ZIDX);
    endfunction

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (vld_q[i] && addr_q[i] == bus.in_addr) hit = 1'b1;
        end
    end

    assign bus.in_ready = is_zero(bus.in_addr) ||
                          (!busy_q[bus.in_addr] && !hit);
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        vld_d[0]  = accept;
        addr_d[0] = bus.in_addr;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
        // select is decoded one stage early so out_sel is a flop output
        sel_d = '0;
        if (vld_d[LAT-1] && !is_zero(addr_d[LAT-1]))
            sel_d[addr_d[LAT-1]] = 1'b1;
    end

    // a killed output-stage entry must not mark its register busy
    assign set_en = vld_q[LAT-1] && !bus.flush &&
                    !is_zero(addr_q[LAT-1]);

    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid && !is_zero(bus.wb_addr))
            busy_d[bus.wb_addr] = 1'b0;
        if (set_en)
            busy_d[addr_q[LAT-1]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            sel_q  <= '0;
            busy_q <= '0;
            for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
            if (bus.flush) begin
                vld_q <= '0;
                sel_q <= '0;
            end else begin
                vld_q <= vld_d;
                sel_q <= sel_d;
            end
        end
    end

    assign bus.out_valid = vld_q[LAT-1];
    assign bus.out_addr  = addr_q[LAT-1];
    assign bus.out_sel   = sel_q;
    assign bus.busy      = busy_q;

    a_set_clr: assert property (@(posedge clk) disable iff (reset)
        !(set_en && bus.wb_valid && bus.wb_addr == addr_q[LAT-1]));
endmodule

// File: tb/tb_pipelined_write_decoder.sv
// Randomized bench: three decoders (LAT 1..3) share request stimulus
// and are compared cycle by cycle against a queue-based model.
module tb_pipelined_write_decoder;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int ND = 3;
    localparam int ZI = 31;

    typedef struct {
        int addr;
        int age;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                   iv, fl;
    logic [AW-1:0]          ia;
    logic [ND-1:0]          wv, rdy, ov;
    logic [ND-1:0][AW-1:0]  wa, oa;
    logic [ND-1:0][NR-1:0]  os, bz;

    for (genvar g = 0; g < ND; g++) begin : u
        pipelined_write_decoder_if #(.ADDR_W(AW)) bus ();
        pipelined_write_decoder #(
            .ADDR_W(AW), .LAT(g + 1), .ZERO_EN(1), .ZERO_IDX(ZI)
        ) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus)
        );
        assign bus.in_valid = iv;
        assign bus.in_addr  = ia;
        assign bus.flush    = fl;
        assign bus.wb_valid = wv[g];
        assign bus.wb_addr  = wa[g];
        assign rdy[g] = bus.in_ready;
        assign ov[g]  = bus.out_valid;
        assign oa[g]  = bus.out_addr;
        assign os[g]  = bus.out_sel;
        assign bz[g]  = bus.busy;
    end

    ent_t q [ND][$];
    bit   mb[ND][NR];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    function automatic bit m_rdy(int d, int a);
        if (a == ZI) return 1'b1;
        if (mb[d][a]) return 1'b0;
        foreach (q[d][i]) if (q[d][i].addr == a) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_out(input int d, output bit v, output int a);
        v = 1'b0;
        a = 0;
        foreach (q[d][i]) begin
            if (q[d][i].age == d + 1) begin
                v = 1'b1;
                a = q[d][i].addr;
            end
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < ND; d++) begin
            q[d].delete();
            for (int r = 0; r < NR; r++) mb[d][r] = 1'b0;
        end
    endtask

    task automatic m_advance(input int d, input bit acc);
        ent_t nq[$];
        if (wv[d] && int'(wa[d]) != ZI) mb[d][wa[d]] = 1'b0;
        if (!fl) begin
            foreach (q[d][i]) begin
                if (q[d][i].age == d + 1) begin
                    if (q[d][i].addr != ZI) mb[d][q[d][i].addr] = 1'b1;
                end else begin
                    nq.push_back('{addr: q[d][i].addr, age: q[d][i].age + 1});
                end
            end
            if (acc) nq.push_back('{addr: int'(ia), age: 1});
        end
        q[d] = nq;
    endtask

    task automatic pick_wb(input int d);
        int  lst[$];
        int  a, oa_m;
        bit  ov_m;
        wv[d] = 1'b0;
        if ($urandom_range(0, 2) != 0) return;
        for (int r = 0; r < NR; r++) if (mb[d][r]) lst.push_back(r);
        if (lst.size() > 0 && $urandom_range(0, 3) != 0)
            a = lst[$urandom_range(0, lst.size() - 1)];
        else
            a = $urandom_range(0, NR - 1);
        m_out(d, ov_m, oa_m);
        if (ov_m && oa_m == a) return;
        wv[d] = 1'b1;
        wa[d] = AW'(a);
    endtask

    // wb: -1 random per DUT, -2 none, else that index on every DUT
    task automatic step(input bit v, input int a, input bit f,
                        input int wb);
        bit              acc[ND];
        bit              ev;
        int              ea;
        logic [31:0]     eos, ebz;
        @(negedge clk);
        iv = v;
        ia = AW'(a);
        fl = f;
        for (int d = 0; d < ND; d++) begin
            if (wb == -1) pick_wb(d);
            else if (wb == -2) wv[d] = 1'b0;
            else begin
                wv[d] = 1'b1;
                wa[d] = AW'(wb);
            end
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            m_out(d, ev, ea);
            eos = (ev && ea != ZI) ? (32'd1 << ea) : 32'd0;
            for (int r = 0; r < NR; r++) ebz[r] = mb[d][r];
            check($sformatf("rdy%0d", d), 32'(rdy[d]), 32'(m_rdy(d, a)));
            check($sformatf("ov%0d", d), 32'(ov[d]), 32'(ev));
            check($sformatf("sel%0d", d), os[d], eos);
            check($sformatf("busy%0d", d), bz[d], ebz);
            if (ev) check($sformatf("oa%0d", d), 32'(oa[d]), 32'(ea));
            acc[d] = v && m_rdy(d, a);
        end
        for (int d = 0; d < ND; d++) m_advance(d, acc[d]);
    endtask

    initial begin
        iv = 1'b0;
        ia = '0;
        fl = 1'b0;
        wv = '0;
        wa = '0;
        m_reset();
        #1;
        for (int d = 0; d < ND; d++) begin
            check("rst_rdy", 32'(rdy[d]), 32'd1);
            check("rst_ov", 32'(ov[d]), 32'd0);
            check("rst_sel", os[d], 32'd0);
            check("rst_busy", bz[d], 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        step(1'b1, 5, 1'b0, -2);
        step(1'b0, 0, 1'b0, -2);
        check("l1_ov", 32'(ov[0]), 32'd1);
        check("l1_sel", os[0], 32'h0000_0020);
        check("l1_oa", 32'(oa[0]), 32'd5);
        step(1'b0, 0, 1'b0, -2);
        check("l1_busy5", 32'(bz[0][5]), 32'd1);

        step(1'b1, 7, 1'b0, -2);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 7, 1'b0, -2);
            check("hold7", 32'(rdy[0]), 32'd0);
        end
        step(1'b1, 7, 1'b0, 7);
        check("hold7_wb", 32'(rdy[0]), 32'd0);
        step(1'b0, 7, 1'b0, -2);
        check("free7", 32'(rdy[0]), 32'd1);

        for (int k = 0; k < 3; k++) begin
            step(1'b1, ZI, 1'b0, -2);
            check("z_rdy", 32'(rdy[2]), 32'd1);
            if (k > 0) begin
                check("z_ov", 32'(ov[0]), 32'd1);
                check("z_sel", os[0], 32'd0);
            end
        end
        step(1'b0, 0, 1'b0, -2);
        check("z_busy", 32'(bz[2][ZI]), 32'd0);

        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0, -2);
        for (int k = 1; k <= 3; k++) step(1'b1, k, 1'b0, -2);
        step(1'b1, 2, 1'b0, -2);
        check("l3_inflight", 32'(rdy[2]), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 0, 1'b0, -2);

        step(1'b1, 9, 1'b0, -2);
        step(1'b0, 0, 1'b1, -2);
        for (int k = 0; k < 4; k++) step(1'b0, 9, 1'b0, -2);
        check("fl_busy9", 32'(bz[1][9]), 32'd0);
        check("fl_rdy9", 32'(rdy[1]), 32'd1);

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 9) == 0) ? ZI : $urandom_range(0, 11),
                 $urandom_range(0, 29) == 0, -1);
            if (n == 700) begin
                #2 reset = 1'b1;
                #1;
                for (int d = 0; d < ND; d++) begin
                    check("ar_ov", 32'(ov[d]), 32'd0);
                    check("ar_sel", os[d], 32'd0);
                    check("ar_busy", bz[d], 32'd0);
                end
                m_reset();
                iv = 1'b0;
                fl = 1'b0;
                wv = '0;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
